// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code assembler: folds E0/F0 prefixes into single key events,
// tags hex digits and Enter, and queues the events in a small valid/ready FIFO.
//
// state   | meaning
// IDLE    | waiting for the first byte of a sequence
// EXT     | E0 seen, waiting for code or F0
// BRK     | F0 seen, waiting for the released key code
// EXT_BRK | E0 F0 seen, waiting for the released extended key code
module ps2_key_decoder #(
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 200000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       tick,
  input  logic       correct,
  input  logic       ev_ready,
  input  logic       err_clr,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_release,
  output logic       ev_ext,
  output logic       ev_is_hex,
  output logic [3:0] ev_hex,
  output logic       ev_enter,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          held_valid;
  logic          held_ext;
  logic [7:0]    held_code;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic is_e0, is_f0, is_prefix;
  logic emit, emit_rel, emit_ext;
  logic held_match, drop_rep, push, pop, full, push_ok;
  logic [4:0] hex_map;
  logic [15:0] head;

  function automatic logic [4:0] hex_lookup(input logic [7:0] c);
    case (c)
      8'h45: return 5'h10;
      8'h16: return 5'h11;
      8'h1E: return 5'h12;
      8'h26: return 5'h13;
      8'h25: return 5'h14;
      8'h2E: return 5'h15;
      8'h36: return 5'h16;
      8'h3D: return 5'h17;
      8'h3E: return 5'h18;
      8'h46: return 5'h19;
      8'h1C: return 5'h1A;
      8'h32: return 5'h1B;
      8'h21: return 5'h1C;
      8'h23: return 5'h1D;
      8'h24: return 5'h1E;
      8'h2B: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign is_e0     = (code == 8'hE0);
  assign is_f0     = (code == 8'hF0);
  assign is_prefix = is_e0 | is_f0;

  always_comb begin
    emit     = 1'b0;
    emit_rel = 1'b0;
    emit_ext = 1'b0;
    if (tick && correct && !is_prefix) begin
      emit = 1'b1;
      case (state)
        IDLE:    ;
        EXT:     emit_ext = 1'b1;
        BRK:     emit_rel = 1'b1;
        EXT_BRK: begin emit_rel = 1'b1; emit_ext = 1'b1; end
        default: emit = 1'b0;
      endcase
    end
  end

  assign held_match = held_valid && (held_ext == emit_ext) && (held_code == code);
  assign drop_rep   = SUPPRESS_REPEAT && emit && !emit_rel && held_match;
  assign push       = emit && !drop_rep;
  assign hex_map    = emit_ext ? 5'h00 : hex_lookup(code);

  assign ev_valid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else if (tick) begin
      tmo_cnt <= '0;
      if (!correct) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
          EXT:     state <= is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
          default: state <= IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // A break of a different key leaves the held key alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= '0;
    end else if (emit && !emit_rel && !drop_rep) begin
      held_valid <= 1'b1;
      held_ext   <= emit_ext;
      held_code  <= code;
    end else if (emit && emit_rel && held_match) begin
      held_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {code, emit_rel, emit_ext, hex_map, code == 8'h5A};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (tick && !correct) frame_err <= 1'b1;
      else if (err_clr)     frame_err <= 1'b0;
      if (push && full && !pop) overflow <= 1'b1;
      else if (err_clr)         overflow <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_code    = head[15:8];
  assign ev_release = head[7];
  assign ev_ext     = head[6];
  assign ev_is_hex  = head[5];
  assign ev_hex     = head[4:1];
  assign ev_enter   = head[0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: sequences, repeat suppression, timeout,
// frame errors, FIFO overflow and same-cycle push/pop, reset mid-sequence.
module tb_ps2_key_decoder;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code;
  logic       tick, correct, ev_ready, err_clr;
  logic       ev_valid, ev_release, ev_ext, ev_is_hex, ev_enter, frame_err, overflow;
  logic [7:0] ev_code;
  logic [3:0] ev_hex;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk(clk), .rst(rst), .code(code), .tick(tick), .correct(correct),
    .ev_ready(ev_ready), .err_clr(err_clr), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_release(ev_release), .ev_ext(ev_ext), .ev_is_hex(ev_is_hex), .ev_hex(ev_hex),
    .ev_enter(ev_enter), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, ev_valid, ev_code, ev_release, ev_ext, ev_is_hex, ev_hex, ev_enter,
            frame_err, overflow};
  endfunction

  // Head event packed as {valid, code, release, ext, is_hex, hex, enter}
  function automatic logic [31:0] head_now();
    return {15'd0, ev_valid, ev_code, ev_release, ev_ext, ev_is_hex, ev_hex, ev_enter};
  endfunction

  function automatic logic [31:0] ev_exp(input logic [7:0] c, input logic rel, input logic ext,
                                         input logic ish, input logic [3:0] h, input logic ent);
    return {15'd0, 1'b1, c, rel, ext, ish, h, ent};
  endfunction

  task automatic send_byte(input logic [7:0] c, input logic ok);
    @(posedge clk); #1;
    code = c; tick = 1'b1; correct = ok;
    @(posedge clk); #1;
    tick = 1'b0; correct = 1'b0;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; code = '0; tick = 1'b0; correct = 1'b0; ev_ready = 1'b0; err_clr = 1'b0;
    #3;
    check("reset_outputs", all_outs(), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single hex make, then pop
    send_byte(8'h16, 1'b1);
    check("make_16", head_now(), ev_exp(8'h16, 0, 0, 1, 4'h1, 0));
    pop_one();
    check("pop_16_empty", ev_valid, 0);

    // Extended break of Enter
    send_byte(8'hE0, 1'b1);
    check("no_ev_after_e0", ev_valid, 0);
    send_byte(8'hF0, 1'b1);
    check("no_ev_after_f0", ev_valid, 0);
    send_byte(8'h5A, 1'b1);
    check("ext_brk_5a", head_now(), ev_exp(8'h5A, 1, 1, 0, 4'h0, 1));
    pop_one();
    check("pop_5a_empty", ev_valid, 0);

    // Typematic repeat suppression
    send_byte(8'h1C, 1'b1);
    send_byte(8'h1C, 1'b1);
    send_byte(8'h1C, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h1C, 1'b1);
    check("rep_make_1c", head_now(), ev_exp(8'h1C, 0, 0, 1, 4'hA, 0));
    pop_one();
    check("rep_brk_1c", head_now(), ev_exp(8'h1C, 1, 0, 1, 4'hA, 0));
    pop_one();
    check("rep_only_two", ev_valid, 0);

    // Prefix timeout drops back to IDLE silently
    send_byte(8'hE0, 1'b1);
    repeat (TMO + 2) @(posedge clk);
    #1;
    send_byte(8'h23, 1'b1);
    check("tmo_23", head_now(), ev_exp(8'h23, 0, 0, 1, 4'hD, 0));
    check("tmo_no_err", frame_err, 0);
    pop_one();

    // Frame error and its clear
    send_byte(8'h29, 1'b0);
    check("ferr_set", frame_err, 1);
    check("ferr_no_ev", ev_valid, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("ferr_clr", frame_err, 0);

    // Overflow with five makes into a 4-deep FIFO
    send_byte(8'h45, 1'b1);
    send_byte(8'h16, 1'b1);
    send_byte(8'h1E, 1'b1);
    send_byte(8'h26, 1'b1);
    check("ovf_not_yet", overflow, 0);
    send_byte(8'h25, 1'b1);
    check("ovf_set", overflow, 1);
    check("ovf_head_45", head_now(), ev_exp(8'h45, 0, 0, 1, 4'h0, 0));
    pop_one();
    check("ovf_head_16", head_now(), ev_exp(8'h16, 0, 0, 1, 4'h1, 0));
    pop_one();
    check("ovf_head_1e", head_now(), ev_exp(8'h1E, 0, 0, 1, 4'h2, 0));
    pop_one();
    check("ovf_head_26", head_now(), ev_exp(8'h26, 0, 0, 1, 4'h3, 0));
    pop_one();
    check("ovf_drained", ev_valid, 0);

    // Reset in the middle of a break sequence; overflow is still set here
    send_byte(8'hF0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midseq_reset_outputs", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'h2E, 1'b1);
    check("post_rst_2e", head_now(), ev_exp(8'h2E, 0, 0, 1, 4'h5, 0));

    // Fill to full, then push and pop in the same cycle
    send_byte(8'h3D, 1'b1);
    send_byte(8'h3E, 1'b1);
    send_byte(8'h46, 1'b1);
    @(posedge clk); #1;
    code = 8'h24; tick = 1'b1; correct = 1'b1; ev_ready = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; correct = 1'b0; ev_ready = 1'b0;
    check("full_pushpop_no_ovf", overflow, 0);
    check("fp_head_3d", head_now(), ev_exp(8'h3D, 0, 0, 1, 4'h7, 0));
    pop_one();
    check("fp_head_3e", head_now(), ev_exp(8'h3E, 0, 0, 1, 4'h8, 0));
    pop_one();
    check("fp_head_46", head_now(), ev_exp(8'h46, 0, 0, 1, 4'h9, 0));
    pop_one();
    check("fp_head_24", head_now(), ev_exp(8'h24, 0, 0, 1, 4'hE, 0));
    pop_one();
    check("fp_drained", ev_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits between the PS/2 frame receiver and the application core.
- Consumes raw scan-code bytes (code, tick, correct) and assembles Set-2 make/break/extended sequences into single key events.
- Maps hex digits and Enter.
- Buffers events in a small FIFO with a valid/ready handshake, so the core never misses a key while busy.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 200000, max clk cycles allowed between a prefix byte (E0/F0) and the next byte (2 ms at 100 MHz).
- SUPPRESS_REPEAT, 1, when 1, typematic repeat makes of the currently held key are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- code  in  8  received scan-code byte; valid only when tick=1
- tick  in  1  one-cycle strobe: a new byte is on code
- correct  in  1  parity/stop check of the byte at tick; 1=good
- ev_ready  in  1  consumer accepts the head event
- err_clr  in  1  synchronous clear of frame_err and overflow
- ev_valid  out  1  FIFO non-empty; head event presented
- ev_code  out  8  head event base scan code, prefixes stripped
- ev_release  out  1  head event is a break (key up)
- ev_ext  out  1  head event carried the E0 prefix
- ev_is_hex  out  1  head event is a non-extended 0-9/A-F key
- ev_hex  out  4  hex value when ev_is_hex=1, else 0
- ev_enter  out  1  head event code is 0x5A (extended or not)
- frame_err  out  1  sticky: a byte arrived with correct=0
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async, any time, including mid-sequence):
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0; held-key register cleared; timeout counter is 0.
- Byte acceptance: only on cycles with tick=1. tick with correct=0:
  - Sets frame_err.
  - Discards the byte and any partial sequence; FSM returns to IDLE.
- FSM states and transitions on a good byte:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> emit make (ext=0).
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit make (ext=1).
  - BRK: other -> emit break (ext=0); E0/F0 -> protocol error, drop, back to IDLE.
  - EXT_BRK: other -> emit break (ext=1); E0/F0 -> drop, back to IDLE.
  - Every emit returns the FSM to IDLE.
- Timeout:
  - Counter runs only in EXT/BRK/EXT_BRK and reloads on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no event and no error flag.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - Held register {valid, ext, code} is set by each emitted make.
  - A make equal to the held key is dropped.
  - A break matching the held key clears the held register.
  - A break of another key leaves the held register unchanged.
- Hex map (only when ext=0):
  - 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
  - The map is computed at push and stored in the FIFO entry.
- Latency: event is written on the clk edge where the final byte's tick is sampled; ev_valid=1 in the following cycle.
- FIFO:
  - Entry = {code, release, ext, is_hex, hex, enter}.
  - Head is presented combinationally from storage.
  - Pop happens when ev_valid & ev_ready; ev_ready is ignored when ev_valid=0.
  - Push while full with no pop in the same cycle: event dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- err_clr clears both sticky flags. If a set condition occurs in the same cycle, the set wins.

Test Plan:
- Byte 0x16, ev_ready=0 -> 1 cycle later ev_valid=1, ev_code=16, ev_is_hex=1, ev_hex=1, release=0, ext=0. Then ev_ready=1 for 1 cycle -> ev_valid=0.
- Sequence E0, F0, 5A -> single event: code=5A, ext=1, release=1, ev_enter=1, ev_is_hex=0. No event after E0 or after F0.
- Sequence 1C, 1C, 1C, F0, 1C with SUPPRESS_REPEAT=1 -> exactly two events: make 1C (hex=A) and break 1C.
- Byte E0, then idle for TIMEOUT_CYCLES, then 23 -> one event code=23, ext=0, hex=D. Byte 29 with correct=0 -> frame_err=1, no event. err_clr -> frame_err=0.
- With ev_ready=0, send five distinct makes 45, 16, 1E, 26, 25 -> four events held, overflow=1. Then pop four -> codes 45, 16, 1E, 26 in order.
- Send F0, assert rst mid-sequence, release rst, then send 2E -> make event with hex=5, release=0. All outputs were 0 while reset was active.
